// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port unified memory.
// The core has fixed priority, bounded by a streak counter so that the
// DMA/loader port always makes progress. Memory-side signals are registered
// and read data is steered back to whichever requester issued the read.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    typedef enum logic {
        CORE_PRI = 1'b0,
        DMA_TURN = 1'b1
    } state_t;

    localparam logic [3:0] STREAK_LAST = 4'(MAX_STREAK - 1);
    localparam logic [3:0] STREAK_MAX  = 4'(MAX_STREAK);

    state_t     state;
    logic [3:0] streak;
    logic       pend_c_p0;
    logic       pend_d_p0;

    // Grant decision: core wins unless the DMA has been given its turn
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!Reset) begin
            if (c_req && (!d_req || state == CORE_PRI))
                c_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
        end
    end

    assign c_stall = c_req & ~c_gnt;

    // Anti-starvation streak counter and priority state
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= CORE_PRI;
            streak <= 4'd0;
        end else begin
            case (state)
                CORE_PRI: begin
                    if (c_gnt && d_req) begin
                        if (streak == STREAK_LAST) begin
                            state  <= DMA_TURN;
                            streak <= STREAK_MAX;
                        end else begin
                            streak <= streak + 4'd1;
                        end
                    end else if (c_gnt || d_gnt) begin
                        streak <= 4'd0;
                    end
                end
                DMA_TURN: begin
                    if (d_gnt || !d_req) begin
                        state  <= CORE_PRI;
                        streak <= 4'd0;
                    end
                end
                default: begin
                    state  <= CORE_PRI;
                    streak <= 4'd0;
                end
            endcase
        end
    end

    // Issue stage: register the winner's request onto the memory port
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            pend_c_p0 <= 1'b0;
            pend_d_p0 <= 1'b0;
        end else begin
            mem_en    <= c_gnt | d_gnt;
            mem_we    <= (c_gnt & c_we) | (d_gnt & d_we);
            pend_c_p0 <= c_gnt & ~c_we;
            pend_d_p0 <= d_gnt & ~d_we;
            if (c_gnt) begin
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
                owner     <= 1'b0;
            end else if (d_gnt) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                owner     <= 1'b1;
            end
        end
    end

    // Return stage: memory has sampled the read, its data arrives now
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= pend_c_p0;
            d_rvalid <= pend_d_p0;
        end
    end

    assign c_rdata = c_rvalid ? mem_rdata : '0;
    assign d_rdata = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory, a
// per-cycle reference model of arbitration and a read-data scoreboard.
module tb_mem_port_arbiter;

    logic        CLK;
    logic        Reset;
    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
    logic [15:0] c_rdata, d_rdata;
    logic        mem_en, mem_we, owner;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int ntest = 0;
    int nfail = 0;
    int cyc   = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_STREAK(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Initial memory contents (before any write)
    function automatic logic [15:0] preset(input logic [7:0] a);
        case (a)
            8'h10:   preset = 16'hBEEF;
            8'h01:   preset = 16'h1111;
            8'h02:   preset = 16'h2222;
            default: preset = {a, ~a};
        endcase
    endfunction

    // Behavioural synchronous-read memory
    logic [15:0] mem_arr [256];
    bit          mem_wr  [256];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr[7:0]] <= mem_wdata;
                mem_wr[mem_addr[7:0]]  <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : preset(mem_addr[7:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t cq[$];
    exp_t dq[$];

    // Reference model state
    logic [15:0] ref_arr [256];
    bit          ref_wr  [256];
    bit          m_dma_turn = 0;
    int          m_streak   = 0;
    logic        e_en = 0, e_we = 0, e_owner = 0;
    logic [15:0] e_addr = 0, e_wdata = 0;

    // Per-cycle model check, sampled mid-cycle while inputs are stable
    always @(negedge CLK) begin
        bit eg_c, eg_d;
        exp_t e;
        if (Reset) begin
            m_dma_turn = 0; m_streak = 0;
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_owner = 0;
            cq.delete(); dq.delete();
            chk("rst_c_gnt", {31'd0, c_gnt}, 0);
            chk("rst_d_gnt", {31'd0, d_gnt}, 0);
            chk("rst_mem_en", {31'd0, mem_en}, 0);
            chk("rst_mem_addr", {16'd0, mem_addr}, 0);
            chk("rst_mem_wdata", {16'd0, mem_wdata}, 0);
            chk("rst_rvalid", {30'd0, c_rvalid, d_rvalid}, 0);
        end else begin
            chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
            chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata});
            chk("owner", {31'd0, owner}, {31'd0, e_owner});
            if (cq.size() > 0 && cq[0].due == cyc) begin
                e = cq.pop_front();
                chk("c_rvalid", {31'd0, c_rvalid}, 1);
                chk("c_rdata", {16'd0, c_rdata}, {16'd0, e.data});
                chk("d_rdata_idle", {16'd0, d_rdata}, 0);
            end else begin
                chk("c_rvalid_idle", {31'd0, c_rvalid}, 0);
                chk("c_rdata_idle", {16'd0, c_rdata}, 0);
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                chk("d_rvalid", {31'd0, d_rvalid}, 1);
                chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.data});
                chk("c_rdata_idle", {16'd0, c_rdata}, 0);
            end else begin
                chk("d_rvalid_idle", {31'd0, d_rvalid}, 0);
                chk("d_rdata_idle", {16'd0, d_rdata}, 0);
            end
            eg_c = c_req && (!d_req || !m_dma_turn);
            eg_d = d_req && !eg_c;
            chk("c_gnt", {31'd0, c_gnt}, {31'd0, eg_c});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
            chk("c_stall", {31'd0, c_stall}, {31'd0, c_req & ~eg_c});
            e_en = eg_c | eg_d;
            e_we = (eg_c & c_we) | (eg_d & d_we);
            if (eg_c || eg_d) begin
                e_addr  = eg_c ? c_addr : d_addr;
                e_wdata = eg_c ? c_wdata : d_wdata;
                e_owner = eg_d;
                if (e_we) begin
                    ref_arr[e_addr[7:0]] = e_wdata;
                    ref_wr[e_addr[7:0]]  = 1'b1;
                end else begin
                    e.data = ref_wr[e_addr[7:0]] ? ref_arr[e_addr[7:0]] : preset(e_addr[7:0]);
                    e.due  = cyc + 2;
                    if (eg_c) cq.push_back(e);
                    else      dq.push_back(e);
                end
            end
            if (!m_dma_turn) begin
                if (eg_c && d_req) begin
                    m_streak++;
                    if (m_streak == 4) m_dma_turn = 1;
                end else if (eg_c || eg_d) begin
                    m_streak = 0;
                end
            end else if (eg_d || !d_req) begin
                m_dma_turn = 0;
                m_streak   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request and hold it until granted
    task automatic issue(input bit dma, input logic we, input logic [15:0] a, input logic [15:0] wd);
        bit g;
        int n;
        if (dma) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else     begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; end
        g = 0;
        n = 0;
        while (!g && n < 50) begin
            @(negedge CLK);
            g = dma ? d_gnt : c_gnt;
            tick();
            n++;
        end
        if (!g) begin
            ntest++;
            nfail++;
            $error("FAIL issue_timeout: observed no grant expected grant within 50 cycles");
        end
        if (dma) d_req = 0;
        else     c_req = 0;
    endtask

    initial begin
        int          dcnt;
        logic [4:0]  pat;
        for (int i = 0; i < 256; i++) begin
            ref_wr[i] = 1'b0;
            ref_arr[i] = 16'h0;
        end
        Reset = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        #2 Reset = 1;
        tick(); tick();
        Reset = 0;
        tick();

        // Core read only
        issue(0, 0, 16'h0010, 16'h0);
        repeat (3) tick();

        // Contention: expect C,C,C,C,D repeating
        c_req = 1; c_we = 0; c_addr = 16'h0020;
        d_req = 1; d_we = 0; d_addr = 16'h0030;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            dcnt += int'(d_gnt);
            tick();
        end
        chk("contention_dma_grants", dcnt, 3);
        c_req = 0; d_req = 0;
        repeat (3) tick();

        // Interleaved reads on consecutive edges
        issue(0, 0, 16'h0001, 16'h0);
        issue(1, 0, 16'h0002, 16'h0);
        repeat (3) tick();

        // DMA write then core read of the same address
        issue(1, 1, 16'h0040, 16'h5A5A);
        issue(0, 0, 16'h0040, 16'h0);
        repeat (3) tick();

        // Reset the cycle after a core read grant
        issue(0, 0, 16'h0010, 16'h0);
        Reset = 1;
        tick(); tick();
        Reset = 0;
        repeat (3) tick();

        // Reach DMA_TURN, then drop d_req
        c_req = 1; c_we = 0; c_addr = 16'h0021;
        d_req = 1; d_we = 0; d_addr = 16'h0031;
        repeat (4) tick();
        d_req = 0;
        @(negedge CLK);
        chk("drop_core_gnt", {31'd0, c_gnt}, 1);
        tick();
        d_req = 1;
        pat = 5'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            pat = {pat[3:0], d_gnt};
            tick();
        end
        chk("streak_restart_pattern", {27'd0, pat}, 32'h1);
        c_req = 0; d_req = 0;
        repeat (5) tick();

        chk("scoreboard_empty", cq.size() + dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
